instr_fetch_stage: RTL and testbench
====================================

INSTR_FETCH_STAGE -- requirements
Module: instr_fetch_stage

Interface
REQ-001 SHALL have parameter PC_W, default 8, giving the PC and address width in bits.
REQ-002 SHALL have parameter INSTR_W, default 8, giving the instruction width in bits.
REQ-003 SHALL have parameter IMM_S_W, default 3, giving the short immediate field width, bits [IMM_S_W-1:0].
REQ-004 SHALL have parameter IMM_L_W, default 6, giving the long immediate field width, bits [IMM_L_W-1:0].
REQ-005 SHALL have parameter RESET_PC, default 0, giving the PC value after reset.
REQ-006 SHALL have port Clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port Imem_Addr, output, PC_W bits: fetch address, equal to the PC register.
REQ-009 SHALL have port Imem_Data, input, INSTR_W bits: instruction at Imem_Addr, valid combinationally in the same cycle.
REQ-010 SHALL have port PCSrc, input, 1 bit: when 1, the fetched instruction is a PC-relative jump.
REQ-011 SHALL have port ImmSel, input, 1 bit: 1 selects the long immediate, 0 selects the short immediate.
REQ-012 SHALL have port Redirect_Valid, input, 1 bit: absolute redirect request from a later stage.
REQ-013 SHALL have port Redirect_PC, input, PC_W bits: redirect target address.
REQ-014 SHALL have port Out_Valid, output, 1 bit: the IF/ID register holds a valid instruction.
REQ-015 SHALL have port Out_Ready, input, 1 bit: decode accepts the IF/ID contents this cycle.
REQ-016 SHALL have port Out_Instr, output, INSTR_W bits: registered instruction.
REQ-017 SHALL have port Out_Imm, output, PC_W bits: registered sign-extended immediate.
REQ-018 SHALL have port Out_PC, output, PC_W bits: registered address of Out_Instr.

Function
REQ-019 Imm SHALL be sign-extended to PC_W bits: bits [IMM_L_W-1:0] of Imem_Data when ImmSel=1, else bits [IMM_S_W-1:0].
REQ-020 A fetch SHALL fire when Reset=0, Redirect_Valid=0 and (Out_Valid=0 or Out_Ready=1).
REQ-021 On a fire, the IF/ID register SHALL load Out_Instr=Imem_Data, Out_Imm=Imm and Out_PC=PC, and set Out_Valid=1.
REQ-022 On a fire, PC SHALL become PC+1 when PCSrc=0, and PC+1+Imm when PCSrc=1.
REQ-023 All PC arithmetic SHALL be modulo 2^PC_W, so 0xFF+1 wraps to 0x00 at the defaults.
REQ-024 With Out_Valid=1 and Out_Ready=0 (stall), PC and all Out_* SHALL hold their values; PCSrc and ImmSel SHALL be ignored.
REQ-025 With Out_Valid=1, Out_Ready=1 and no fire possible, Out_Valid SHALL clear next cycle; this case is unreachable except under redirect.
REQ-026 Redirect_Valid=1 SHALL set PC=Redirect_PC and Out_Valid=0 at the next edge, regardless of Out_Ready or PCSrc; no fetch fires in that cycle.
REQ-027 The stage SHALL sustain one instruction per cycle when Out_Ready is held at 1.
REQ-028 Out_Instr, Out_Imm and Out_PC SHALL be don't-care while Out_Valid=0.

Reset
REQ-029 Reset=1 at a rising edge SHALL set PC=RESET_PC, Out_Valid=0, Out_Instr=0, Out_Imm=0 and Out_PC=0.
REQ-030 Reset SHALL take priority over Redirect_Valid and over fetch, including when asserted mid-stall.
REQ-031 The first fetch SHALL occur at the first edge with Reset=0, at address RESET_PC.

Structure
REQ-032 Shared package if_pkg SHALL hold the default widths (PC_W, INSTR_W, IMM_S_W, IMM_L_W) and RESET_PC.
REQ-033 Sign extension SHALL be one sub-module, imm_sign_ext, parametrised by the field width and PC_W.
REQ-034 The PC register and the IF/ID register SHALL be the only state.

Verification
REQ-035 Reset held 2 cycles, then released, Out_Ready=1 -> Imem_Addr=0x00, Out_Valid=0 on the first cycle after release; next cycle Out_Valid=1, Out_PC=0x00.
REQ-036 Sequential, PCSrc=0, Out_Ready=1 from PC=0xFE -> Imem_Addr sequence 0xFE, 0xFF, 0x00, 0x01; Out_PC trails Imem_Addr by one cycle.
REQ-037 PC=0x05, Imem_Data=0x06, ImmSel=0, PCSrc=1 -> Out_Imm=0xFE; next PC=0x04.
REQ-038 PC=0x10, Imem_Data=0x1F, ImmSel=1, PCSrc=1 -> Out_Imm=0x1F; next PC=0x30.
REQ-039 Out_Valid=1, Out_Ready=0 for 3 cycles with PCSrc toggling -> Imem_Addr and Out_* stable; Out_Ready=1 -> fetch resumes from the held PC.
REQ-040 Stall with Redirect_Valid=1, Redirect_PC=0x40 -> next cycle Out_Valid=0, Imem_Addr=0x40; same cycle with Reset=1 -> Imem_Addr=RESET_PC.

Source files
------------

// File: rtl/if_pkg.sv
// -----------------------------------------------------------------------------
// if_pkg
// Shared defaults for the instruction fetch stage: PC / instruction widths,
// short and long immediate field widths, and the PC value loaded on reset.
// -----------------------------------------------------------------------------
package if_pkg;

   localparam int IF_PC_W     = 8;
   localparam int IF_INSTR_W  = 8;
   localparam int IF_IMM_S_W  = 3;
   localparam int IF_IMM_L_W  = 6;
   localparam int IF_RESET_PC = 0;

endpackage

// File: rtl/imm_sign_ext.sv
// -----------------------------------------------------------------------------
// imm_sign_ext
// Sign-extends a FIELD_W-bit immediate field to OUT_W bits.
//   field_i : immediate field, two's complement, FIELD_W bits
//   ext_o   : sign-extended result, OUT_W bits (OUT_W must exceed FIELD_W)
// -----------------------------------------------------------------------------
module imm_sign_ext #(
   parameter int FIELD_W = 3,
   parameter int OUT_W   = 8
) (
   input  logic [FIELD_W-1:0] field_i,
   output logic [OUT_W-1:0]   ext_o
);

   assign ext_o = {{(OUT_W-FIELD_W){field_i[FIELD_W-1]}}, field_i};

endmodule

// File: rtl/instr_fetch_stage.sv
// -----------------------------------------------------------------------------
// instr_fetch_stage
// Single-cycle instruction fetch with PC-relative jumps, absolute redirect and
// a valid/ready IF/ID output register.
//   Clk, Reset       : clock and synchronous active-high reset
//   Imem_Addr        : fetch address (the PC register)
//   Imem_Data        : instruction at Imem_Addr, combinational same cycle
//   PCSrc            : fetched instruction is a PC-relative jump
//   ImmSel           : 1 = long immediate field, 0 = short immediate field
//   Redirect_Valid/PC: absolute redirect from a later stage (flushes IF/ID)
//   Out_Valid/Ready  : IF/ID handshake towards decode
//   Out_Instr/Imm/PC : registered instruction, sign-extended immediate, address
// -----------------------------------------------------------------------------
module instr_fetch_stage
   import if_pkg::*;
#(
   parameter int PC_W     = IF_PC_W,
   parameter int INSTR_W  = IF_INSTR_W,
   parameter int IMM_S_W  = IF_IMM_S_W,
   parameter int IMM_L_W  = IF_IMM_L_W,
   parameter int RESET_PC = IF_RESET_PC
) (
   input  logic               Clk,
   input  logic               Reset,
   output logic [PC_W-1:0]    Imem_Addr,
   input  logic [INSTR_W-1:0] Imem_Data,
   input  logic               PCSrc,
   input  logic               ImmSel,
   input  logic               Redirect_Valid,
   input  logic [PC_W-1:0]    Redirect_PC,
   output logic               Out_Valid,
   input  logic               Out_Ready,
   output logic [INSTR_W-1:0] Out_Instr,
   output logic [PC_W-1:0]    Out_Imm,
   output logic [PC_W-1:0]    Out_PC
);

   logic [PC_W-1:0]    pc_q, pc_d;
   logic               out_valid_q, out_valid_d;
   logic [INSTR_W-1:0] out_instr_q, out_instr_d;
   logic [PC_W-1:0]    out_imm_q, out_imm_d;
   logic [PC_W-1:0]    out_pc_q, out_pc_d;

   logic [PC_W-1:0]    imm_s, imm_l, imm;
   logic               fire;

   imm_sign_ext #(.FIELD_W(IMM_S_W), .OUT_W(PC_W)) u_ext_short (
      .field_i (Imem_Data[IMM_S_W-1:0]),
      .ext_o   (imm_s)
   );

   imm_sign_ext #(.FIELD_W(IMM_L_W), .OUT_W(PC_W)) u_ext_long (
      .field_i (Imem_Data[IMM_L_W-1:0]),
      .ext_o   (imm_l)
   );

   assign imm = ImmSel ? imm_l : imm_s;

   // Fetch only when the IF/ID slot is free or being drained; a redirect
   // suppresses the fetch because the instruction at the old PC is stale.
   assign fire = !Redirect_Valid && (!out_valid_q || Out_Ready);

   always_comb begin
      pc_d        = pc_q;
      out_valid_d = out_valid_q;
      out_instr_d = out_instr_q;
      out_imm_d   = out_imm_q;
      out_pc_d    = out_pc_q;
      if (Redirect_Valid) begin
         pc_d        = Redirect_PC;
         out_valid_d = 1'b0;
      end else if (fire) begin
         out_valid_d = 1'b1;
         out_instr_d = Imem_Data;
         out_imm_d   = imm;
         out_pc_d    = pc_q;
         // Jump target is relative to the next sequential PC; wraps mod 2^PC_W.
         pc_d        = pc_q + PC_W'(1) + (PCSrc ? imm : '0);
      end
      // Otherwise stalled (valid and not ready): everything holds.
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         pc_q        <= PC_W'(RESET_PC);
         out_valid_q <= 1'b0;
         out_instr_q <= '0;
         out_imm_q   <= '0;
         out_pc_q    <= '0;
      end else begin
         pc_q        <= pc_d;
         out_valid_q <= out_valid_d;
         out_instr_q <= out_instr_d;
         out_imm_q   <= out_imm_d;
         out_pc_q    <= out_pc_d;
      end
   end

   assign Imem_Addr = pc_q;
   assign Out_Valid = out_valid_q;
   assign Out_Instr = out_instr_q;
   assign Out_Imm   = out_imm_q;
   assign Out_PC    = out_pc_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
module tb_instr_fetch_stage;

   logic       Clk = 1'b0;
   logic       Reset;
   logic [7:0] Imem_Addr;
   logic [7:0] Imem_Data;
   logic       PCSrc;
   logic       ImmSel;
   logic       Redirect_Valid;
   logic [7:0] Redirect_PC;
   logic       Out_Valid;
   logic       Out_Ready;
   logic [7:0] Out_Instr;
   logic [7:0] Out_Imm;
   logic [7:0] Out_PC;

   logic [7:0] mem [256];
   assign Imem_Data = mem[Imem_Addr];

   always #5 Clk = ~Clk;

   instr_fetch_stage dut (
      .Clk            (Clk),
      .Reset          (Reset),
      .Imem_Addr      (Imem_Addr),
      .Imem_Data      (Imem_Data),
      .PCSrc          (PCSrc),
      .ImmSel         (ImmSel),
      .Redirect_Valid (Redirect_Valid),
      .Redirect_PC    (Redirect_PC),
      .Out_Valid      (Out_Valid),
      .Out_Ready      (Out_Ready),
      .Out_Instr      (Out_Instr),
      .Out_Imm        (Out_Imm),
      .Out_PC         (Out_PC)
   );

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [7:0] instr;
      logic [7:0] imm;
      logic [7:0] pc;
   } exp_t;
   exp_t exp_q[$];

   logic [7:0] m_pc;
   logic       m_valid;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Immediate model: value of the field, minus 2^W when its top bit is set.
   function automatic logic [7:0] m_imm(input logic [7:0] d, input logic sel);
      logic [7:0] v;
      if (sel) begin
         v = {2'b00, d[5:0]};
         if (d[5]) v = v - 8'd64;
      end else begin
         v = {5'b00000, d[2:0]};
         if (d[2]) v = v - 8'd8;
      end
      return v;
   endfunction

   // One clock: inputs are already set. Consume/flush the scoreboard, advance
   // the model, step the clock, then check address and valid.
   task automatic cycle();
      exp_t e;
      if (!Reset && m_valid && Out_Ready) begin
         if (exp_q.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("sb_instr", {24'd0, Out_Instr}, {24'd0, e.instr});
            chk("sb_imm",   {24'd0, Out_Imm},   {24'd0, e.imm});
            chk("sb_pc",    {24'd0, Out_PC},    {24'd0, e.pc});
         end
      end
      if (Reset) begin
         exp_q.delete();
         m_pc    = 8'h00;
         m_valid = 1'b0;
      end else if (Redirect_Valid) begin
         if (m_valid && !Out_Ready && exp_q.size() > 0) void'(exp_q.pop_front());
         m_pc    = Redirect_PC;
         m_valid = 1'b0;
      end else if (!m_valid || Out_Ready) begin
         e.instr = mem[m_pc];
         e.imm   = m_imm(mem[m_pc], ImmSel);
         e.pc    = m_pc;
         exp_q.push_back(e);
         m_pc    = m_pc + 8'd1 + (PCSrc ? e.imm : 8'd0);
         m_valid = 1'b1;
      end
      @(posedge Clk);
      #1;
      chk("addr",  {24'd0, Imem_Addr}, {24'd0, m_pc});
      chk("valid", {31'd0, Out_Valid}, {31'd0, m_valid});
   endtask

   typedef struct {
      logic [7:0] start_pc;
      logic [7:0] data;
      logic       immsel;
      logic       pcsrc;
      logic [7:0] exp_imm;
      logic [7:0] exp_next;
   } vec_t;
   vec_t tbl[7];

   logic [7:0] s_addr, s_instr, s_imm, s_pc;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      tbl[0] = '{8'h05, 8'h06, 1'b0, 1'b1, 8'hFE, 8'h04};
      tbl[1] = '{8'h10, 8'h1F, 1'b1, 1'b1, 8'h1F, 8'h30};
      tbl[2] = '{8'h20, 8'h03, 1'b0, 1'b1, 8'h03, 8'h24};
      tbl[3] = '{8'h60, 8'h04, 1'b0, 1'b1, 8'hFC, 8'h5D};
      tbl[4] = '{8'h30, 8'h20, 1'b1, 1'b1, 8'hE0, 8'h11};
      tbl[5] = '{8'h80, 8'hFF, 1'b1, 1'b0, 8'hFF, 8'h81};
      tbl[6] = '{8'hFF, 8'h01, 1'b0, 1'b1, 8'h01, 8'h01};

      Reset = 1'b1; PCSrc = 1'b0; ImmSel = 1'b0;
      Redirect_Valid = 1'b0; Redirect_PC = 8'h00; Out_Ready = 1'b1;
      m_pc = 8'h00; m_valid = 1'b0;

      // Reset held two cycles, then released.
      cycle(); cycle();
      chk("rst_instr", {24'd0, Out_Instr}, 32'd0);
      chk("rst_imm",   {24'd0, Out_Imm},   32'd0);
      chk("rst_pc",    {24'd0, Out_PC},    32'd0);
      Reset = 1'b0;
      chk("rel_addr",  {24'd0, Imem_Addr}, 32'h00);
      chk("rel_valid", {31'd0, Out_Valid}, 32'd0);
      cycle();
      chk("first_valid", {31'd0, Out_Valid}, 32'd1);
      chk("first_pc",    {24'd0, Out_PC},    32'h00);

      // Sequential run across the wrap point.
      Redirect_Valid = 1'b1; Redirect_PC = 8'hFE; cycle();
      Redirect_Valid = 1'b0; PCSrc = 1'b0;
      chk("seq_addr0", {24'd0, Imem_Addr}, 32'hFE);
      cycle();
      chk("seq_addr1", {24'd0, Imem_Addr}, 32'hFF);
      chk("seq_opc1",  {24'd0, Out_PC},    32'hFE);
      cycle();
      chk("seq_addr2", {24'd0, Imem_Addr}, 32'h00);
      chk("seq_opc2",  {24'd0, Out_PC},    32'hFF);
      cycle();
      chk("seq_addr3", {24'd0, Imem_Addr}, 32'h01);
      chk("seq_opc3",  {24'd0, Out_PC},    32'h00);

      // Table of immediate / jump vectors, each entered via redirect.
      for (int i = 0; i < 7; i++) begin
         mem[tbl[i].start_pc] = tbl[i].data;
         Redirect_Valid = 1'b1; Redirect_PC = tbl[i].start_pc; Out_Ready = 1'b1;
         cycle();
         Redirect_Valid = 1'b0; PCSrc = tbl[i].pcsrc; ImmSel = tbl[i].immsel;
         cycle();
         chk("tbl_imm",   {24'd0, Out_Imm},   {24'd0, tbl[i].exp_imm});
         chk("tbl_instr", {24'd0, Out_Instr}, {24'd0, tbl[i].data});
         chk("tbl_opc",   {24'd0, Out_PC},    {24'd0, tbl[i].start_pc});
         chk("tbl_next",  {24'd0, Imem_Addr}, {24'd0, tbl[i].exp_next});
      end

      // Stall for three cycles with PCSrc toggling, then resume.
      PCSrc = 1'b0; Out_Ready = 1'b1; cycle();
      Out_Ready = 1'b0;
      s_addr = Imem_Addr; s_instr = Out_Instr; s_imm = Out_Imm; s_pc = Out_PC;
      for (int i = 0; i < 3; i++) begin
         PCSrc = ~PCSrc; ImmSel = ~ImmSel;
         cycle();
         chk("stall_addr",  {24'd0, Imem_Addr}, {24'd0, s_addr});
         chk("stall_instr", {24'd0, Out_Instr}, {24'd0, s_instr});
         chk("stall_imm",   {24'd0, Out_Imm},   {24'd0, s_imm});
         chk("stall_pc",    {24'd0, Out_PC},    {24'd0, s_pc});
      end
      Out_Ready = 1'b1; PCSrc = 1'b0;
      cycle();
      chk("resume_opc",  {24'd0, Out_PC},    {24'd0, s_addr});
      chk("resume_addr", {24'd0, Imem_Addr}, {24'd0, s_addr + 8'd1});

      // Redirect during a stall flushes IF/ID.
      Out_Ready = 1'b0; Redirect_Valid = 1'b1; Redirect_PC = 8'h40;
      cycle();
      chk("redir_valid", {31'd0, Out_Valid}, 32'd0);
      chk("redir_addr",  {24'd0, Imem_Addr}, 32'h40);
      Redirect_Valid = 1'b0;
      cycle();
      // Reset wins over redirect during a stall.
      Redirect_Valid = 1'b1; Reset = 1'b1;
      cycle();
      chk("rstredir_addr",  {24'd0, Imem_Addr}, 32'h00);
      chk("rstredir_valid", {31'd0, Out_Valid}, 32'd0);
      Reset = 1'b0; Redirect_Valid = 1'b0;

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         Out_Ready      = ($urandom_range(0, 3) != 0);
         PCSrc          = 1'($urandom);
         ImmSel         = 1'($urandom);
         Redirect_Valid = ($urandom_range(0, 15) == 0);
         Redirect_PC    = 8'($urandom);
         Reset          = ($urandom_range(0, 63) == 0);
         cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
